// File: rtl/alu_iter_if.sv
// Issue/result handshake bundle between the execute stage and alu_iter.
// The core side uses the master modport, the ALU the slave modport.
interface alu_iter_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result, result_hi, flags
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result, result_hi, flags
    );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts, shift-add multiply.
// Define ALU_ITER_DIV_EN to build the restoring divider for op 9; otherwise op 9 is reserved.
module alu_iter #(
    parameter int WIDTH = 16
) (
    input logic        clk,
    input logic        rst,
    alu_iter_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0, OP_SUB  = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR  = 4'd4, OP_NOT  = 4'd5, OP_SHR = 4'd6, OP_SHL = 4'd7,
        OP_MULU = 4'd8, OP_DIVU = 4'd9
    } op_e;

    state_e           state_q;
    op_e              op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, p_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic [3:0]       flags_q;

    op_e              op_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] imm_res, imm_hi, a_init;
    logic             imm_c, imm_v, imm_busy;
    logic [CW-1:0]    imm_cnt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] it_a, it_p;
    logic             it_c;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                               input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    assign op_in  = op_e'(bus.op);
    assign shamt  = bus.src1[SHW-1:0];
    assign sum_w  = {1'b0, bus.src1} + {1'b0, bus.src2};
    assign diff_w = {1'b0, bus.src1} - {1'b0, bus.src2};

    // Result of an op resolved at accept, or the set-up for an iterative one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        imm_res  = '0;
        imm_hi   = '0;
        imm_c    = 1'b0;
        imm_v    = 1'b0;
        imm_busy = 1'b0;
        imm_cnt  = '0;
        a_init   = bus.src1;
        case (op_in)
            OP_ADD: begin
                imm_res = sum_w[WIDTH-1:0];
                imm_c   = sum_w[WIDTH];
                imm_v   = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != bus.src1[WIDTH-1]);
            end
            OP_SUB: begin
                imm_res = diff_w[WIDTH-1:0];
                imm_c   = diff_w[WIDTH];
                imm_v   = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != bus.src1[WIDTH-1]);
            end
            OP_AND: imm_res = bus.src1 & bus.src2;
            OP_OR:  imm_res = bus.src1 | bus.src2;
            OP_XOR: imm_res = bus.src1 ^ bus.src2;
            OP_NOT: imm_res = ~bus.src2;
            OP_SHR, OP_SHL: begin
                a_init = bus.src2;
                if (shamt == '0) begin
                    imm_res = bus.src2;
                end else begin
                    imm_busy = 1'b1;
                    imm_cnt  = {1'b0, shamt};
                end
            end
            OP_MULU: begin
                imm_busy = 1'b1;
                imm_cnt  = CW'(WIDTH);
            end
`ifdef ALU_ITER_DIV_EN
            OP_DIVU: begin
                if (bus.src2 == '0) begin
                    imm_res = '1;
                    imm_hi  = bus.src1;
                    imm_c   = 1'b1;
                end else begin
                    imm_busy = 1'b1;
                    imm_cnt  = CW'(WIDTH);
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef ALU_ITER_DIV_EN
    logic [WIDTH:0] div_shift, div_diff;
    assign div_shift = {p_q, a_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
`endif

    assign mul_sum = {1'b0, p_q} + (a_q[0] ? {1'b0, b_q} : '0);

    // One iteration step; p_q is the high half (product high / partial remainder).
    always_comb begin
        it_a = a_q;
        it_p = p_q;
        it_c = 1'b0;
        case (op_q)
            OP_SHR: begin
                it_a = a_q >> 1;
                it_c = a_q[0];
            end
            OP_SHL: begin
                it_a = a_q << 1;
                it_c = a_q[WIDTH-1];
            end
            OP_MULU: begin
                it_p = mul_sum[WIDTH:1];
                it_a = {mul_sum[0], a_q[WIDTH-1:1]};
                it_c = (mul_sum[WIDTH:1] != '0);
            end
`ifdef ALU_ITER_DIV_EN
            OP_DIVU: begin
                if (!div_diff[WIDTH]) begin
                    it_p = div_diff[WIDTH-1:0];
                    it_a = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    it_p = div_shift[WIDTH-1:0];
                    it_a = {a_q[WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= op_in;
                        a_q  <= a_init;
                        b_q  <= bus.src2;
                        p_q  <= '0;
                        if (imm_busy) begin
                            cnt_q   <= imm_cnt;
                            state_q <= S_BUSY;
                        end else begin
                            result_q    <= imm_res;
                            result_hi_q <= imm_hi;
                            flags_q     <= pack_flags(imm_res, imm_c, imm_v);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    a_q   <= it_a;
                    p_q   <= it_p;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q    <= it_a;
                        result_hi_q <= it_p;
                        flags_q     <= pack_flags(it_a, it_c, 1'b0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH = 16; follows ALU_ITER_DIV_EN for op 9 expectations.
module tb_alu_iter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_if #(.WIDTH(W)) bus ();
    alu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Accept one op, then count edges until out_valid (bounded).
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit rdy_early, output int lat, output bit rdy_busy);
        bus.op        = op;
        bus.src1      = a;
        bus.src2      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy_early;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.src1     = ~a;
        bus.src2     = ~b;
        lat      = 1;
        rdy_busy = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_busy = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.in_ready) rdy_busy = 1'b1;
    endtask

    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                          input logic [3:0] exp_flags, input int exp_lat, input bit rdy_early);
        int lat;
        bit rdy_busy;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        start_op(op, a, b, rdy_early, lat, rdy_busy);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " in_ready_low"}, 32'(rdy_busy), 32'd0);
        check({tag, " result"}, 32'(bus.result), 32'(exp_res));
        check({tag, " result_hi"}, 32'(bus.result_hi), 32'(exp_hi));
        check({tag, " flags"}, 32'(bus.flags), 32'(exp_flags));
        finish_op(tag);
    endtask

    initial begin
        int lat;
        bit rdy_busy;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst result", 32'(bus.result), 32'd0);
        check("rst result_hi", 32'(bus.result_hi), 32'd0);
        check("rst flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;
        #1;

        // flags = {S, Z, C, V}
        run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1001, 1, 1'b0);
        run_op("sub_borrow", 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 4'b1010, 1, 1'b0);
        run_op("sub_ovf", 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1, 1'b0);
        run_op("and", 4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 4'b0000, 1, 1'b0);
        run_op("or", 4'd3, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000, 4'b1000, 1, 1'b0);
        run_op("xor", 4'd4, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0000, 4'b1000, 1, 1'b0);
        run_op("not", 4'd5, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 4'b0100, 1, 1'b0);
        run_op("shr1", 4'd6, 16'h0001, 16'h0003, 16'h0001, 16'h0000, 4'b0010, 2, 1'b0);
        run_op("shl4", 4'd7, 16'h0004, 16'h8001, 16'h0010, 16'h0000, 4'b0000, 5, 1'b0);
        run_op("shr0", 4'd6, 16'h0010, 16'hABCD, 16'hABCD, 16'h0000, 4'b1000, 1, 1'b0);
        run_op("shl_early_rdy", 4'd7, 16'h0003, 16'hF00F, 16'h8078, 16'h0000, 4'b1010, 4, 1'b1);
        run_op("mulu_max", 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 17, 1'b0);
        run_op("mulu_small", 4'd8, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 17, 1'b0);
`ifdef ALU_ITER_DIV_EN
        run_op("divu", 4'd9, 16'd100, 16'd7, 16'd14, 16'd2, 4'b0000, 17, 1'b0);
        run_op("divu_zero", 4'd9, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b1010, 1, 1'b0);
`else
        run_op("op9_reserved", 4'd9, 16'd100, 16'd7, 16'h0000, 16'h0000, 4'b0100, 1, 1'b0);
`endif
        run_op("reserved12", 4'd12, 16'h5555, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100, 1, 1'b0);

        // Result must hold while the consumer stalls.
        start_op(4'd0, 16'h1111, 16'h2222, 1'b0, lat, rdy_busy);
        check("hold latency", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
            check("hold result", 32'(bus.result), 32'h3333);
            check("hold flags", 32'(bus.flags), 32'd0);
        end
        finish_op("hold");

        // Reset in the middle of a multiply discards it.
        bus.op       = 4'd8;
        bus.src1     = 16'hFFFF;
        bus.src2     = 16'hFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mul_busy in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid result", 32'(bus.result), 32'd0);
        rst = 1'b0;
        #1;
        run_op("add_after_rst", 4'd0, 16'd2, 16'd3, 16'd5, 16'h0000, 4'b0000, 1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("no_stale out_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
